// File: rtl/gousheh_pkg.sv
// Shared descriptor type codes, beat-count decode and error bit positions
// for the Gousheh descriptor path.
package gousheh_pkg;

  localparam logic [3:0] DESC_TYPE_DONE0  = 4'd0;
  localparam logic [3:0] DESC_TYPE_DONE1  = 4'd1;
  localparam logic [3:0] DESC_TYPE_DONE2  = 4'd2;
  localparam logic [3:0] DESC_TYPE_DRAM_RD = 4'd4;
  localparam logic [3:0] DESC_TYPE_DRAM_WR = 4'd5;
  localparam logic [3:0] DESC_TYPE_EXT    = 4'd6;
  localparam logic [3:0] DESC_TYPE_TRI    = 4'd7;

  localparam int unsigned ERR_DUPL_SLOT     = 0;
  localparam int unsigned ERR_INV_SLOT      = 1;
  localparam int unsigned ERR_STRAY_RELEASE = 2;
  localparam int unsigned ERR_W             = 3;

  // Beats occupied by a core descriptor of the given type.
  function automatic int unsigned nbeats(input logic [3:0] desc_type,
                                         input int unsigned max_beats);
    int unsigned n;
    n = 1;
    case (desc_type)
      DESC_TYPE_DRAM_RD, DESC_TYPE_DRAM_WR: n = 2;
      DESC_TYPE_EXT:                        n = max_beats;
      DESC_TYPE_TRI:                        n = (max_beats < 3) ? max_beats : 3;
      default:                              n = 1;
    endcase
    return n;
  endfunction

  function automatic logic is_done_type(input logic [3:0] desc_type);
    return (desc_type == DESC_TYPE_DONE0) || (desc_type == DESC_TYPE_DONE1) ||
           (desc_type == DESC_TYPE_DONE2);
  endfunction

endpackage

// File: rtl/gousheh_slot_bitmap.sv
// In-progress slot bitmap with sticky error detection and a registered
// popcount that tracks the bitmap cycle for cycle.
module gousheh_slot_bitmap
  import gousheh_pkg::*;
#(
  parameter int unsigned SLOT_COUNT = 16,
  parameter int unsigned SLOT_W     = $clog2(SLOT_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_reset,
  input  logic                  alloc_valid,
  input  logic [SLOT_W-1:0]     alloc_slot,
  input  logic                  rel_valid,
  input  logic [SLOT_W-1:0]     rel_slot,
  input  logic [ERR_W-1:0]      err_clr,
  output logic [SLOT_COUNT-1:0] slots_in_prog,
  output logic [SLOT_W-1:0]     active_slots,
  output logic [ERR_W-1:0]      err_flags
);

  logic [SLOT_COUNT-1:0] alloc_mask_c;
  logic [SLOT_COUNT-1:0] rel_mask_c;
  logic [SLOT_COUNT-1:0] slots_next_c;
  logic [ERR_W-1:0]      err_set_c;
  logic [SLOT_W-1:0]     count_next_c;

  // One-hot slot decode; an all-zero mask marks an out-of-range slot ID.
  always_comb begin
    alloc_mask_c = '0;
    rel_mask_c   = '0;
    for (int i = 0; i < int'(SLOT_COUNT); i++) begin
      alloc_mask_c[i] = (alloc_slot == SLOT_W'(i + 1));
      rel_mask_c[i]   = (rel_slot == SLOT_W'(i + 1));
    end
  end

  // Release is applied before allocate so a same-slot swap ends with the bit set.
  always_comb begin
    slots_next_c = slots_in_prog;
    err_set_c    = '0;
    if (rel_valid) begin
      if (rel_mask_c == '0) begin
        err_set_c[ERR_INV_SLOT] = 1'b1;
      end else if ((slots_in_prog & rel_mask_c) == '0) begin
        err_set_c[ERR_STRAY_RELEASE] = 1'b1;
      end else begin
        slots_next_c = slots_next_c & ~rel_mask_c;
      end
    end
    if (alloc_valid) begin
      if (alloc_mask_c == '0) begin
        err_set_c[ERR_INV_SLOT] = 1'b1;
      end else begin
        if ((slots_next_c & alloc_mask_c) != '0) begin
          err_set_c[ERR_DUPL_SLOT] = 1'b1;
        end
        slots_next_c = slots_next_c | alloc_mask_c;
      end
    end
  end

  always_comb begin
    count_next_c = '0;
    for (int i = 0; i < int'(SLOT_COUNT); i++) begin
      count_next_c = count_next_c + SLOT_W'(slots_next_c[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_in_prog <= '0;
      active_slots  <= '0;
      err_flags     <= '0;
    end else if (core_reset) begin
      slots_in_prog <= '0;
      active_slots  <= '0;
      err_flags     <= '0;
    end else begin
      slots_in_prog <= slots_next_c;
      active_slots  <= count_next_c;
      err_flags     <= (err_flags & ~err_clr) | err_set_c;
    end
  end

endmodule

// File: rtl/gousheh_desc_tracker.sv
// Core descriptor serialiser with in-progress slot tracking; beats pass
// straight through, only the beat index and the slot state are registered.
module gousheh_desc_tracker
  import gousheh_pkg::*;
#(
  parameter int unsigned DESC_WIDTH = 64,
  parameter int unsigned MAX_BEATS  = 4,
  parameter int unsigned SLOT_COUNT = 16,
  parameter int unsigned SLOT_LSB   = 16,
  parameter int unsigned TYPE_LSB   = 60
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            core_reset,
  input  logic [DESC_WIDTH-1:0]           in_desc_mon,
  input  logic                            in_desc_valid_mon,
  input  logic                            in_desc_taken_mon,
  input  logic [MAX_BEATS*DESC_WIDTH-1:0] core_desc_data,
  input  logic                            core_desc_valid,
  output logic                            core_desc_ready,
  output logic [DESC_WIDTH-1:0]           out_desc,
  output logic [$clog2(MAX_BEATS)-1:0]    out_desc_beat,
  output logic                            out_desc_last,
  output logic                            out_desc_valid,
  input  logic                            out_desc_ready,
  output logic [SLOT_COUNT-1:0]           slots_in_prog,
  output logic [$clog2(SLOT_COUNT+1)-1:0] active_slots,
  output logic [ERR_W-1:0]                err_flags,
  input  logic [ERR_W-1:0]                err_clr
);

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS);
  localparam int unsigned SLOT_W = $clog2(SLOT_COUNT + 1);

  logic [BEAT_W-1:0] cnt;
  logic [3:0]        desc_type_c;
  logic [BEAT_W-1:0] last_idx_c;
  logic              beat_hs_c;
  logic              release_c;

  assign desc_type_c = core_desc_data[TYPE_LSB +: 4];
  assign last_idx_c  = BEAT_W'(nbeats(desc_type_c, MAX_BEATS) - 1);

  // Beat mux selected by the running beat index.
  always_comb begin
    out_desc = '0;
    for (int k = 0; k < int'(MAX_BEATS); k++) begin
      if (cnt == BEAT_W'(k)) begin
        out_desc = core_desc_data[k*DESC_WIDTH +: DESC_WIDTH];
      end
    end
  end

  assign out_desc_beat   = cnt;
  assign out_desc_last   = (cnt == last_idx_c);
  assign out_desc_valid  = core_desc_valid;
  assign core_desc_ready = out_desc_ready && out_desc_last;
  assign beat_hs_c       = core_desc_valid && out_desc_ready;
  assign release_c       = beat_hs_c && out_desc_last && is_done_type(desc_type_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (core_reset) begin
      cnt <= '0;
    end else if (beat_hs_c) begin
      cnt <= out_desc_last ? '0 : cnt + BEAT_W'(1);
    end
  end

  gousheh_slot_bitmap #(
    .SLOT_COUNT (SLOT_COUNT),
    .SLOT_W     (SLOT_W)
  ) u_slot_bitmap (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_reset    (core_reset),
    .alloc_valid   (in_desc_valid_mon && in_desc_taken_mon),
    .alloc_slot    (in_desc_mon[SLOT_LSB +: SLOT_W]),
    .rel_valid     (release_c),
    .rel_slot      (core_desc_data[SLOT_LSB +: SLOT_W]),
    .err_clr       (err_clr),
    .slots_in_prog (slots_in_prog),
    .active_slots  (active_slots),
    .err_flags     (err_flags)
  );

endmodule

// File: tb/tb_gousheh_desc_tracker.sv
// Directed bench for gousheh_desc_tracker with hand-computed expectations.
module tb_gousheh_desc_tracker;

  logic         clk;
  logic         rst_n;
  logic         core_reset;
  logic [63:0]  in_desc_mon;
  logic         in_desc_valid_mon;
  logic         in_desc_taken_mon;
  logic [255:0] core_desc_data;
  logic         core_desc_valid;
  logic         core_desc_ready;
  logic [63:0]  out_desc;
  logic [1:0]   out_desc_beat;
  logic         out_desc_last;
  logic         out_desc_valid;
  logic         out_desc_ready;
  logic [15:0]  slots_in_prog;
  logic [4:0]   active_slots;
  logic [2:0]   err_flags;
  logic [2:0]   err_clr;

  int checks = 0;
  int errors = 0;

  gousheh_desc_tracker dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_reset        (core_reset),
    .in_desc_mon       (in_desc_mon),
    .in_desc_valid_mon (in_desc_valid_mon),
    .in_desc_taken_mon (in_desc_taken_mon),
    .core_desc_data    (core_desc_data),
    .core_desc_valid   (core_desc_valid),
    .core_desc_ready   (core_desc_ready),
    .out_desc          (out_desc),
    .out_desc_beat     (out_desc_beat),
    .out_desc_last     (out_desc_last),
    .out_desc_valid    (out_desc_valid),
    .out_desc_ready    (out_desc_ready),
    .slots_in_prog     (slots_in_prog),
    .active_slots      (active_slots),
    .err_flags         (err_flags),
    .err_clr           (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [3:0] t, input logic [4:0] s,
                                     input logic [15:0] tag);
    logic [63:0] d;
    d = '0;
    d[63:60] = t;
    d[20:16] = s;
    d[15:0]  = tag;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] s);
    in_desc_mon = mk(4'd0, s, 16'h0);
    in_desc_valid_mon = 1'b1;
    in_desc_taken_mon = 1'b1;
  endtask

  task automatic idle();
    in_desc_valid_mon = 1'b0;
    in_desc_taken_mon = 1'b0;
    core_desc_valid = 1'b0;
    err_clr = 3'b000;
    core_reset = 1'b0;
  endtask

  logic [63:0] b0, b1, b2, b3;

  initial begin
    rst_n = 1'b0;
    core_reset = 1'b0;
    in_desc_mon = '0;
    in_desc_valid_mon = 1'b0;
    in_desc_taken_mon = 1'b0;
    core_desc_data = '0;
    core_desc_valid = 1'b0;
    out_desc_ready = 1'b0;
    err_clr = 3'b000;
    #3;
    chk("rst_slots", 64'(slots_in_prog), 64'h0);
    chk("rst_active", 64'(active_slots), 64'd0);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_beat", 64'(out_desc_beat), 64'd0);
    chk("rst_valid", 64'(out_desc_valid), 64'd0);
    #5 rst_n = 1'b1;
    step();

    // Allocate slot 3, then release it with a single-beat type 0 descriptor
    alloc(5'd3);
    step();
    idle();
    #1;
    chk("alloc3_slots", 64'(slots_in_prog), 64'h0004);
    chk("alloc3_active", 64'(active_slots), 64'd1);
    b0 = mk(4'd0, 5'd3, 16'h0011);
    core_desc_data = {192'h0, b0};
    core_desc_valid = 1'b1;
    out_desc_ready = 1'b1;
    #1;
    chk("t0_out", out_desc, b0);
    chk("t0_last", 64'(out_desc_last), 64'd1);
    chk("t0_cready", 64'(core_desc_ready), 64'd1);
    chk("t0_valid", 64'(out_desc_valid), 64'd1);
    step();
    idle();
    #1;
    chk("t0_rel_slots", 64'(slots_in_prog), 64'h0);
    chk("t0_rel_active", 64'(active_slots), 64'd0);
    chk("t0_err", 64'(err_flags), 64'd0);

    // Type 4, two beats, ready 1,0,1
    b0 = mk(4'd4, 5'd0, 16'h00AA);
    b1 = 64'hBBBB_BBBB_0000_BBBB;
    core_desc_data = {128'h0, b1, b0};
    core_desc_valid = 1'b1;
    out_desc_ready = 1'b1;
    #1;
    chk("t4_b0_out", out_desc, b0);
    chk("t4_b0_last", 64'(out_desc_last), 64'd0);
    chk("t4_b0_cready", 64'(core_desc_ready), 64'd0);
    step();
    out_desc_ready = 1'b0;
    #1;
    chk("t4_b1_out", out_desc, b1);
    chk("t4_b1_beat", 64'(out_desc_beat), 64'd1);
    chk("t4_b1_last", 64'(out_desc_last), 64'd1);
    chk("t4_stall_cready", 64'(core_desc_ready), 64'd0);
    step();
    chk("t4_stall_beat", 64'(out_desc_beat), 64'd1);
    out_desc_ready = 1'b1;
    #1;
    chk("t4_b1_cready", 64'(core_desc_ready), 64'd1);
    step();
    idle();
    #1;
    chk("t4_done_beat", 64'(out_desc_beat), 64'd0);
    chk("t4_err", 64'(err_flags), 64'd0);

    // Type 6, MAX_BEATS beats back to back
    b0 = mk(4'd6, 5'd0, 16'h0060);
    b1 = 64'h1111;
    b2 = 64'h2222;
    b3 = 64'h3333;
    core_desc_data = {b3, b2, b1, b0};
    core_desc_valid = 1'b1;
    out_desc_ready = 1'b1;
    #1;
    chk("t6_b0_out", out_desc, b0);
    chk("t6_b0_last", 64'(out_desc_last), 64'd0);
    step();
    chk("t6_b1_out", out_desc, b1);
    chk("t6_b1_last", 64'(out_desc_last), 64'd0);
    step();
    chk("t6_b2_beat", 64'(out_desc_beat), 64'd2);
    chk("t6_b2_last", 64'(out_desc_last), 64'd0);
    step();
    chk("t6_b3_out", out_desc, b3);
    chk("t6_b3_last", 64'(out_desc_last), 64'd1);
    chk("t6_b3_cready", 64'(core_desc_ready), 64'd1);
    step();
    idle();
    #1;
    chk("t6_done_beat", 64'(out_desc_beat), 64'd0);

    // Type 7: three beats
    b0 = mk(4'd7, 5'd0, 16'h0070);
    core_desc_data = {b3, b2, b1, b0};
    core_desc_valid = 1'b1;
    step();
    chk("t7_b1_last", 64'(out_desc_last), 64'd0);
    step();
    chk("t7_b2_last", 64'(out_desc_last), 64'd1);
    step();
    idle();
    #1;
    chk("t7_done_beat", 64'(out_desc_beat), 64'd0);

    // Duplicate allocate of slot 5
    alloc(5'd5);
    step();
    step();
    idle();
    #1;
    chk("dup_err", 64'(err_flags), 64'b001);
    chk("dup_slots", 64'(slots_in_prog), 64'h0010);
    step();
    chk("dup_sticky", 64'(err_flags), 64'b001);
    err_clr = 3'b001;
    step();
    idle();
    #1;
    chk("dup_clr", 64'(err_flags), 64'b000);
    alloc(5'd5);
    err_clr = 3'b001;
    step();
    idle();
    #1;
    chk("set_wins", 64'(err_flags), 64'b001);
    err_clr = 3'b111;
    step();
    idle();

    // Out-of-range allocates
    alloc(5'd0);
    step();
    idle();
    #1;
    chk("inv0_err", 64'(err_flags), 64'b010);
    chk("inv0_slots", 64'(slots_in_prog), 64'h0010);
    err_clr = 3'b010;
    step();
    alloc(5'd17);
    err_clr = 3'b000;
    step();
    idle();
    #1;
    chk("inv17_err", 64'(err_flags), 64'b010);
    chk("inv17_slots", 64'(slots_in_prog), 64'h0010);
    err_clr = 3'b111;
    step();
    idle();

    // Same-cycle release and allocate of slot 7
    alloc(5'd7);
    step();
    idle();
    #1;
    chk("alloc7_active", 64'(active_slots), 64'd2);
    alloc(5'd7);
    core_desc_data = {192'h0, mk(4'd1, 5'd7, 16'h0007)};
    core_desc_valid = 1'b1;
    step();
    idle();
    #1;
    chk("swap7_slots", 64'(slots_in_prog), 64'h0050);
    chk("swap7_err", 64'(err_flags), 64'b000);
    chk("swap7_active", 64'(active_slots), 64'd2);

    // Stray release of unused slot 9, then invalid release of slot 0
    core_desc_data = {192'h0, mk(4'd2, 5'd9, 16'h0009)};
    core_desc_valid = 1'b1;
    step();
    idle();
    #1;
    chk("stray_err", 64'(err_flags), 64'b100);
    chk("stray_slots", 64'(slots_in_prog), 64'h0050);
    err_clr = 3'b100;
    core_desc_data = {192'h0, mk(4'd0, 5'd0, 16'h0000)};
    core_desc_valid = 1'b1;
    step();
    idle();
    #1;
    chk("relinv_err", 64'(err_flags), 64'b010);
    chk("relinv_slots", 64'(slots_in_prog), 64'h0050);

    // Async reset mid type-6 descriptor at beat 2
    b0 = mk(4'd6, 5'd0, 16'h0066);
    core_desc_data = {b3, b2, b1, b0};
    core_desc_valid = 1'b1;
    step();
    step();
    chk("mid_beat2", 64'(out_desc_beat), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_beat", 64'(out_desc_beat), 64'd0);
    chk("arst_slots", 64'(slots_in_prog), 64'h0);
    chk("arst_active", 64'(active_slots), 64'd0);
    chk("arst_err", 64'(err_flags), 64'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_out", out_desc, b0);
    chk("post_rst_last", 64'(out_desc_last), 64'd0);
    step();
    chk("post_rst_beat1", 64'(out_desc_beat), 64'd1);
    idle();

    // Synchronous soft reset
    step();
    alloc(5'd2);
    step();
    idle();
    #1;
    chk("alloc2_slots", 64'(slots_in_prog), 64'h0002);
    core_reset = 1'b1;
    step();
    idle();
    #1;
    chk("sreset_slots", 64'(slots_in_prog), 64'h0);
    chk("sreset_beat", 64'(out_desc_beat), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gousheh_desc_tracker.md
Name: gousheh_desc_tracker

Overview:
- Next-generation descriptor path controller for the Gousheh core wrapper.
- Serialises a wide core descriptor into 1..MAX_BEATS output beats; the beat count is chosen per descriptor type.
- Tracks in-progress slots from the incoming-descriptor monitor and the outgoing done descriptors.
- Flags duplicate-slot, invalid-slot and stray-release errors as sticky bits, and keeps a live active-slot count.

Parameters:
- DESC_WIDTH, 64, width of one descriptor beat.
- MAX_BEATS, 4, maximum beats per core descriptor (must be >= 2).
- SLOT_COUNT, 16, number of valid slots (slot IDs 1..SLOT_COUNT).
- SLOT_LSB, 16, bit position of the slot field within beat 0.
- TYPE_LSB, 60, bit position of the 4-bit type field within beat 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- core_reset  in  1  synchronous soft reset, active-high; same effect as rst_n.
- in_desc_mon  in  DESC_WIDTH  incoming descriptor being monitored.
- in_desc_valid_mon  in  1  incoming descriptor valid.
- in_desc_taken_mon  in  1  incoming descriptor accepted by the core.
- core_desc_data  in  MAX_BEATS*DESC_WIDTH  core descriptor; beat k is at [k*DESC_WIDTH +: DESC_WIDTH].
- core_desc_valid  in  1  core descriptor valid.
- core_desc_ready  out  1  core descriptor consumed.
- out_desc  out  DESC_WIDTH  current output beat.
- out_desc_beat  out  clog2(MAX_BEATS)  index of the current beat.
- out_desc_last  out  1  current beat is the final beat.
- out_desc_valid  out  1  output valid.
- out_desc_ready  in  1  downstream ready.
- slots_in_prog  out  SLOT_COUNT  bitmap; bit i-1 is slot i.
- active_slots  out  clog2(SLOT_COUNT+1)  popcount of slots_in_prog, registered.
- err_flags  out  3  sticky errors: [0] dupl_slot, [1] inv_slot, [2] stray_release.
- err_clr  in  3  per-bit clear of err_flags.

Behaviour:
- Reset, from rst_n low (async) or core_reset high (sync):
  - beat counter = 0, slots_in_prog = 0, active_slots = 0, err_flags = 0.
  - Outputs then follow the combinational rules below with beat = 0.
- Type decode: type = core_desc_data[TYPE_LSB+:4]. nbeats(type):
  - 4 or 5 → 2 beats.
  - 6 → MAX_BEATS.
  - 7 → 3 beats, capped at MAX_BEATS.
  - all others → 1 beat.
- Serialiser (beat counter state, 0..MAX_BEATS-1):
  - out_desc = beat[cnt]; out_desc_beat = cnt; out_desc_last = (cnt == nbeats-1); out_desc_valid = core_desc_valid. Zero-latency pass-through.
  - Beat handshake (valid && ready): if last, cnt → 0 and core_desc_ready = 1 in that same cycle; otherwise cnt increments and core_desc_ready = 0.
  - core_desc_ready = out_desc_ready && out_desc_last.
  - core_desc_data and core_desc_valid must stay stable until core_desc_ready. core_desc_valid dropping mid-descriptor is illegal; cnt holds its value.
- Slot allocate: in_desc_valid_mon && in_desc_taken_mon, slot s = in_desc_mon[SLOT_LSB+:clog2(SLOT_COUNT+1)].
  - s == 0 or s > SLOT_COUNT → set inv_slot; bitmap unchanged.
  - Bit already set and not being released this cycle → set dupl_slot; bit stays 1.
- Slot release: on the last-beat handshake of a type 0/1/2 descriptor. Slot r is taken from beat 0.
  - Invalid r → set inv_slot.
  - Bit not set → set stray_release.
  - Otherwise clear the bit.
- Same-cycle allocate and release:
  - Different slots: both applied.
  - Same slot: release is applied first, then allocate. Final bit = 1, no error.
- active_slots: registered from the next-state bitmap, so it matches slots_in_prog every cycle.
- err_flags:
  - A set in the same cycle as err_clr on the same bit: set wins.
  - Errors never alter the serialiser.

Decomposition:
- gousheh_pkg holds: the type codes (DESC_TYPE_DRAM_RD=4, DESC_TYPE_DRAM_WR=5, DESC_TYPE_EXT=6, DESC_TYPE_TRI=7, done types 0..2), the nbeats function, and the error bit indices.
- One sub-module, gousheh_slot_bitmap: owns the bitmap update, error detection and popcount register. The serialiser stays in the top.

Test Plan:
- Type 0, slot 3, out_desc_ready=1, after an in_desc allocate of slot 3 → one beat with out_desc_last=1, core_desc_ready=1 in the same cycle; slots_in_prog bit2 goes 1→0; active_slots 1→0.
- Type 4 with beats A,B and ready toggling 1,0,1 → out_desc A (beat 0), then B held for one stall cycle, then B accepted; core_desc_ready only on B's handshake.
- Type 6 with MAX_BEATS=4 and ready held 1 → beats 0,1,2,3 on consecutive cycles; last=1 only on beat 3; cnt=0 afterwards.
- Allocate slot 5 twice → err_flags=3'b001 and stays set; err_clr=3'b001 → 0. Allocate slot 0 or 17 → inv_slot set, bitmap unchanged.
- Same-cycle release and allocate of slot 7 → bit6 stays 1, err_flags=0, active_slots unchanged. Release of a slot not in use → stray_release set.
- rst_n asserted mid-way through a type 6 descriptor (cnt=2) → cnt=0 and bitmap cleared immediately, asynchronously. After release, beat 0 is presented again.
